// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// Coin values are expressed in cents at the credit register width.
package vend_pkg;

    localparam int CREDIT_W = 7;

    typedef enum logic [1:0] {
        CREDIT = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } vend_state_t;

    localparam logic [CREDIT_W-1:0] NICKEL_C  = 7'd5;
    localparam logic [CREDIT_W-1:0] DIME_C    = 7'd10;
    localparam logic [CREDIT_W-1:0] QUARTER_C = 7'd25;

endpackage

// File: rtl/vend_if.sv
// Bundle of coin, select, dispenser and change-ejector signals around the controller.
// master = controller side, slave = coin front end / mechanisms side.
interface vend_if;

    logic nickel;
    logic dime;
    logic quarter;
    logic sel_a;
    logic sel_b;
    logic cancel;

    // Dispenser: vend_req stays high until vend_done is sampled high.
    // Change ejector: a nickel moves on every rising edge where chg_valid and
    // chg_ready are both high; chg_valid never drops before that transfer.
    logic vend_req;
    logic vend_item;
    logic vend_done;
    logic chg_valid;
    logic chg_ready;

    logic [vend_pkg::CREDIT_W-1:0] credit;
    logic                          reject;
    vend_pkg::vend_state_t         state;

    modport master (
        input  nickel, dime, quarter, sel_a, sel_b, cancel, vend_done, chg_ready,
        output vend_req, vend_item, chg_valid, credit, reject, state
    );

    modport slave (
        output nickel, dime, quarter, sel_a, sel_b, cancel, vend_done, chg_ready,
        input  vend_req, vend_item, chg_valid, credit, reject, state
    );

endinterface

// File: rtl/vend_coin_arb.sv
// Combinational coin arbiter: picks one coin (quarter > dime > nickel), looks up
// its value and decides whether it fits under the credit ceiling.
module vend_coin_arb
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = 100
) (
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic [CREDIT_W-1:0] credit,
    output logic                any_coin,
    output logic                accept,
    output logic                reject,
    output logic [CREDIT_W-1:0] value
);

    logic            multi;
    logic [CREDIT_W:0] sum;

    always_comb begin
        value = '0;
        if (quarter)     value = QUARTER_C;
        else if (dime)   value = DIME_C;
        else if (nickel) value = NICKEL_C;
    end

    assign any_coin = nickel | dime | quarter;
    assign multi    = (nickel & dime) | (nickel & quarter) | (dime & quarter);

    // One bit wider than credit so the ceiling compare cannot wrap.
    assign sum    = {1'b0, credit} + {1'b0, value};
    assign accept = any_coin & (sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign reject = any_coin & (~accept | multi);

endmodule

// File: rtl/vend_controller.sv
// Vending controller: credit accumulation, product vend handshake and
// nickel-by-nickel change payout, all outputs registered.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE_A    = 15,
    parameter int PRICE_B    = 25,
    parameter int MAX_CREDIT = 100
) (
    input logic   clk,
    input logic   rst,
    vend_if.master bus
);

    localparam logic [CREDIT_W-1:0] PRICE_A_C = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] PRICE_B_C = CREDIT_W'(PRICE_B);

    vend_state_t         state;
    logic [CREDIT_W-1:0] credit;
    logic                vend_req;
    logic                vend_item;
    logic                chg_valid;
    logic                reject;

    logic                any_coin;
    logic                coin_accept;
    logic                coin_reject;
    logic [CREDIT_W-1:0] coin_value;

    vend_coin_arb #(.MAX_CREDIT(MAX_CREDIT)) u_coin_arb (
        .nickel   (bus.nickel),
        .dime     (bus.dime),
        .quarter  (bus.quarter),
        .credit   (credit),
        .any_coin (any_coin),
        .accept   (coin_accept),
        .reject   (coin_reject),
        .value    (coin_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CREDIT;
            credit    <= '0;
            vend_req  <= 1'b0;
            vend_item <= 1'b0;
            chg_valid <= 1'b0;
            reject    <= 1'b0;
        end else begin
            // Coins are refused everywhere except the plain coin path below.
            reject <= any_coin;
            case (state)
                CREDIT: begin
                    if (bus.cancel) begin
                        if (credit != '0) begin
                            state     <= CHANGE;
                            chg_valid <= 1'b1;
                        end
                    end else if (any_coin) begin
                        reject <= coin_reject;
                        if (coin_accept) credit <= credit + coin_value;
                    end else if (bus.sel_a && credit >= PRICE_A_C) begin
                        credit    <= credit - PRICE_A_C;
                        vend_item <= 1'b0;
                        vend_req  <= 1'b1;
                        state     <= VEND;
                    end else if (bus.sel_b && credit >= PRICE_B_C) begin
                        credit    <= credit - PRICE_B_C;
                        vend_item <= 1'b1;
                        vend_req  <= 1'b1;
                        state     <= VEND;
                    end
                end
                VEND: begin
                    if (bus.vend_done) begin
                        vend_req <= 1'b0;
                        if (credit != '0) begin
                            state     <= CHANGE;
                            chg_valid <= 1'b1;
                        end else begin
                            state <= CREDIT;
                        end
                    end
                end
                CHANGE: begin
                    if (chg_valid && bus.chg_ready) begin
                        credit <= credit - NICKEL_C;
                        if (credit == NICKEL_C) begin
                            chg_valid <= 1'b0;
                            state     <= CREDIT;
                        end
                    end
                end
                default: state <= CREDIT;
            endcase
        end
    end

    assign bus.credit    = credit;
    assign bus.vend_req  = vend_req;
    assign bus.vend_item = vend_item;
    assign bus.chg_valid = chg_valid;
    assign bus.reject    = reject;
    assign bus.state     = state;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus a randomized
// run against a cents-level behavioural model.
module tb_vend_controller;
    import vend_pkg::*;

    localparam int PA   = 15;
    localparam int PB   = 25;
    localparam int MAXC = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;

    vend_if bus ();

    vend_controller #(.PRICE_A(PA), .PRICE_B(PB), .MAX_CREDIT(MAXC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = taking coins, 1 = vending, 2 = paying change.
    int m_mode, m_credit, m_req, m_item, m_chg, m_rej;
    logic [CREDIT_W-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.nickel = 0; bus.dime = 0; bus.quarter = 0;
        bus.sel_a = 0; bus.sel_b = 0; bus.cancel = 0;
        bus.vend_done = 0; bus.chg_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic model_step();
        int coins, val;
        coins = int'(bus.nickel) + int'(bus.dime) + int'(bus.quarter);
        m_rej = 0;
        if (rst) begin
            m_mode = 0; m_credit = 0; m_req = 0; m_item = 0; m_chg = 0;
            return;
        end
        if (m_mode == 0) begin
            if (bus.cancel) begin
                m_rej = (coins > 0);
                if (m_credit > 0) begin m_mode = 2; m_chg = 1; end
            end else if (coins > 0) begin
                val = bus.quarter ? 25 : (bus.dime ? 10 : 5);
                if (m_credit + val <= MAXC) begin
                    m_credit += val;
                    m_rej = (coins > 1);
                end else begin
                    m_rej = 1;
                end
            end else if (bus.sel_a && m_credit >= PA) begin
                m_credit -= PA; m_item = 0; m_req = 1; m_mode = 1;
            end else if (bus.sel_b && m_credit >= PB) begin
                m_credit -= PB; m_item = 1; m_req = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            m_rej = (coins > 0);
            if (bus.vend_done) begin
                m_req = 0;
                if (m_credit > 0) begin m_mode = 2; m_chg = 1; end
                else m_mode = 0;
            end
        end else begin
            m_rej = (coins > 0);
            if (bus.chg_ready) begin
                m_credit -= 5;
                if (m_credit == 0) begin m_mode = 0; m_chg = 0; end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            bus.nickel = 1'($urandom_range(0, 1)); bus.dime = 1'($urandom_range(0, 1));
            bus.quarter = 1'($urandom_range(0, 1)); bus.sel_a = 1'($urandom_range(0, 1));
            bus.sel_b = 1'($urandom_range(0, 1)); bus.cancel = 1'($urandom_range(0, 1));
            bus.vend_done = 1'($urandom_range(0, 1)); bus.chg_ready = 1'($urandom_range(0, 1));
            tick();
            total++; if (bus.credit !== 7'd0) begin bad++; $display("FAIL reset_credit: got %0d want 0", bus.credit); end
            total++; if (bus.vend_req !== 1'b0) begin bad++; $display("FAIL reset_vend_req: got %0b want 0", bus.vend_req); end
            total++; if (bus.chg_valid !== 1'b0) begin bad++; $display("FAIL reset_chg_valid: got %0b want 0", bus.chg_valid); end
            total++; if (bus.reject !== 1'b0) begin bad++; $display("FAIL reset_reject: got %0b want 0", bus.reject); end
            total++; if (bus.state !== CREDIT) begin bad++; $display("FAIL reset_state: got %0d want %0d", bus.state, CREDIT); end
        end
        rst = 0;
        idle();
    endtask

    task automatic test_exact_payment();
        do_reset();
        bus.dime = 1; tick(); idle();
        total++; if (bus.credit !== 7'd10) begin bad++; $display("FAIL exact_dime: got %0d want 10", bus.credit); end
        bus.nickel = 1; tick(); idle();
        total++; if (bus.credit !== 7'd15) begin bad++; $display("FAIL exact_nickel: got %0d want 15", bus.credit); end
        total++; if (bus.reject !== 1'b0) begin bad++; $display("FAIL exact_reject: got %0b want 0", bus.reject); end
        bus.sel_a = 1; tick(); idle();
        total++; if (bus.credit !== 7'd0) begin bad++; $display("FAIL exact_sel_credit: got %0d want 0", bus.credit); end
        total++; if (bus.vend_req !== 1'b1) begin bad++; $display("FAIL exact_vend_req: got %0b want 1", bus.vend_req); end
        total++; if (bus.vend_item !== 1'b0) begin bad++; $display("FAIL exact_vend_item: got %0b want 0", bus.vend_item); end
        tick(); tick();
        total++; if (bus.vend_req !== 1'b1) begin bad++; $display("FAIL exact_vend_hold: got %0b want 1", bus.vend_req); end
        bus.vend_done = 1; tick(); idle();
        total++; if (bus.vend_req !== 1'b0) begin bad++; $display("FAIL exact_done_req: got %0b want 0", bus.vend_req); end
        total++; if (bus.chg_valid !== 1'b0) begin bad++; $display("FAIL exact_no_change: got %0b want 0", bus.chg_valid); end
        total++; if (bus.state !== CREDIT) begin bad++; $display("FAIL exact_state: got %0d want %0d", bus.state, CREDIT); end
    endtask

    task automatic test_change();
        int hs;
        bit done;
        do_reset();
        bus.quarter = 1; tick(); idle();
        bus.dime = 1; tick(); idle();
        total++; if (bus.credit !== 7'd35) begin bad++; $display("FAIL change_credit35: got %0d want 35", bus.credit); end
        bus.sel_b = 1; tick(); idle();
        total++; if (bus.credit !== 7'd10) begin bad++; $display("FAIL change_sel_b: got %0d want 10", bus.credit); end
        total++; if (bus.vend_item !== 1'b1) begin bad++; $display("FAIL change_item: got %0b want 1", bus.vend_item); end
        bus.vend_done = 1; tick(); idle();
        total++; if (bus.chg_valid !== 1'b1) begin bad++; $display("FAIL change_valid: got %0b want 1", bus.chg_valid); end
        total++; if (bus.vend_req !== 1'b0) begin bad++; $display("FAIL change_req_drop: got %0b want 0", bus.vend_req); end
        hs = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            bus.chg_ready = 1'(i % 2);
            if (bus.chg_valid && bus.chg_ready) hs++;
            tick();
            if (bus.state == CREDIT) done = 1;
        end
        idle();
        total++; if (!done) begin bad++; $display("FAIL change_timeout: got state %0d want %0d", bus.state, CREDIT); end
        total++; if (hs != 2) begin bad++; $display("FAIL change_handshakes: got %0d want 2", hs); end
        total++; if (bus.credit !== 7'd0) begin bad++; $display("FAIL change_final_credit: got %0d want 0", bus.credit); end
        total++; if (bus.chg_valid !== 1'b0) begin bad++; $display("FAIL change_final_valid: got %0b want 0", bus.chg_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (4) begin bus.quarter = 1; tick(); end
        idle();
        total++; if (bus.credit !== 7'd100) begin bad++; $display("FAIL ovf_full: got %0d want 100", bus.credit); end
        bus.nickel = 1; tick(); idle();
        total++; if (bus.reject !== 1'b1) begin bad++; $display("FAIL ovf_reject: got %0b want 1", bus.reject); end
        total++; if (bus.credit !== 7'd100) begin bad++; $display("FAIL ovf_credit: got %0d want 100", bus.credit); end
        tick();
        total++; if (bus.reject !== 1'b0) begin bad++; $display("FAIL ovf_reject_pulse: got %0b want 0", bus.reject); end
        do_reset();
        bus.dime = 1; tick(); idle();
        bus.sel_a = 1; tick(); idle();
        total++; if (bus.credit !== 7'd10) begin bad++; $display("FAIL low_sel_credit: got %0d want 10", bus.credit); end
        total++; if (bus.vend_req !== 1'b0) begin bad++; $display("FAIL low_sel_req: got %0b want 0", bus.vend_req); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.quarter = 1; bus.nickel = 1; tick(); idle();
        total++; if (bus.credit !== 7'd25) begin bad++; $display("FAIL sim_coin_credit: got %0d want 25", bus.credit); end
        total++; if (bus.reject !== 1'b1) begin bad++; $display("FAIL sim_coin_reject: got %0b want 1", bus.reject); end
        bus.sel_a = 1; bus.sel_b = 1; tick(); idle();
        total++; if (bus.credit !== 7'd10) begin bad++; $display("FAIL sim_sel_credit: got %0d want 10", bus.credit); end
        total++; if (bus.vend_item !== 1'b0) begin bad++; $display("FAIL sim_sel_item: got %0b want 0", bus.vend_item); end
        bus.dime = 1; tick(); idle();
        total++; if (bus.reject !== 1'b1) begin bad++; $display("FAIL sim_vend_reject: got %0b want 1", bus.reject); end
        total++; if (bus.credit !== 7'd10) begin bad++; $display("FAIL sim_vend_credit: got %0d want 10", bus.credit); end
        total++; if (bus.vend_req !== 1'b1) begin bad++; $display("FAIL sim_vend_req: got %0b want 1", bus.vend_req); end
        bus.vend_done = 1; tick(); idle();
        bus.chg_ready = 1; tick(); tick(); idle();
        total++; if (bus.state !== CREDIT) begin bad++; $display("FAIL sim_final_state: got %0d want %0d", bus.state, CREDIT); end
    endtask

    task automatic test_cancel_reset();
        int hs;
        bit done;
        do_reset();
        repeat (3) begin bus.nickel = 1; tick(); end
        idle();
        bus.cancel = 1; tick(); idle();
        total++; if (bus.chg_valid !== 1'b1) begin bad++; $display("FAIL cancel_valid: got %0b want 1", bus.chg_valid); end
        total++; if (bus.credit !== 7'd15) begin bad++; $display("FAIL cancel_credit: got %0d want 15", bus.credit); end
        hs = 0; done = 0;
        bus.chg_ready = 1;
        for (int i = 0; i < 10 && !done; i++) begin
            if (bus.chg_valid) hs++;
            tick();
            if (bus.state == CREDIT) done = 1;
        end
        idle();
        total++; if (!done || hs != 3) begin bad++; $display("FAIL cancel_payout: got %0d nickels want 3", hs); end
        repeat (3) begin bus.nickel = 1; tick(); end
        idle();
        bus.cancel = 1; tick(); idle();
        bus.chg_ready = 1; tick();
        total++; if (bus.credit !== 7'd10) begin bad++; $display("FAIL cancel_first_nickel: got %0d want 10", bus.credit); end
        rst = 1; tick(); rst = 0; idle();
        total++; if (bus.credit !== 7'd0) begin bad++; $display("FAIL midrst_credit: got %0d want 0", bus.credit); end
        total++; if (bus.chg_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b want 0", bus.chg_valid); end
        total++; if (bus.state !== CREDIT) begin bad++; $display("FAIL midrst_state: got %0d want %0d", bus.state, CREDIT); end
    endtask

    task automatic test_random();
        logic [CREDIT_W-1:0] exp_credit;
        vend_state_t exp_state;
        rst = 1;
        idle();
        model_step();
        tick();
        rst = 0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.nickel    = ($urandom_range(0, 4) == 0);
            bus.dime      = ($urandom_range(0, 4) == 0);
            bus.quarter   = ($urandom_range(0, 5) == 0);
            bus.sel_a     = ($urandom_range(0, 4) == 0);
            bus.sel_b     = ($urandom_range(0, 4) == 0);
            bus.cancel    = ($urandom_range(0, 11) == 0);
            bus.vend_done = ($urandom_range(0, 2) == 0);
            bus.chg_ready = ($urandom_range(0, 1) == 0);
            model_step();
            exp_q.push_back(CREDIT_W'(m_credit));
            tick();
            exp_credit = exp_q.pop_front();
            exp_state = (m_mode == 0) ? CREDIT : ((m_mode == 1) ? VEND : CHANGE);
            total++; if (bus.credit !== exp_credit) begin bad++; $display("FAIL rnd_credit cyc %0d: got %0d want %0d", i, bus.credit, exp_credit); end
            total++; if (bus.vend_req !== 1'(m_req)) begin bad++; $display("FAIL rnd_vend_req cyc %0d: got %0b want %0d", i, bus.vend_req, m_req); end
            total++; if (bus.vend_item !== 1'(m_item)) begin bad++; $display("FAIL rnd_vend_item cyc %0d: got %0b want %0d", i, bus.vend_item, m_item); end
            total++; if (bus.chg_valid !== 1'(m_chg)) begin bad++; $display("FAIL rnd_chg_valid cyc %0d: got %0b want %0d", i, bus.chg_valid, m_chg); end
            total++; if (bus.reject !== 1'(m_rej)) begin bad++; $display("FAIL rnd_reject cyc %0d: got %0b want %0d", i, bus.reject, m_rej); end
            total++; if (bus.state !== exp_state) begin bad++; $display("FAIL rnd_state cyc %0d: got %0d want %0d", i, bus.state, exp_state); end
        end
        rst = 0;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_exact_payment();
        test_change();
        test_overflow();
        test_simultaneous();
        test_cancel_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
